// File: rtl/serial_frame_pkg.sv
// rtl/serial_frame_pkg.sv - shared state encoding and line levels for the serial frame receiver
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Level of an idle line (and of a valid stop bit)
  localparam logic IDLE_LEVEL  = 1'b1;
  // Level of a start bit
  localparam logic START_LEVEL = 1'b0;

endpackage

// File: rtl/serial_frame_ctrl_sipo_shift_reg.sv
// rtl/serial_frame_ctrl_sipo_shift_reg.sv - serial-in/parallel-out shift register, first bit ends up in the MSB
module sipo_shift_reg #(
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_shift_en,
  input  logic              i_serial_in,
  output logic [DATA_W-1:0] o_q
);

  logic [DATA_W-1:0] r_q;

  generate
    if (DATA_W == 1) begin : g_one
      // Single-bit word: the register simply captures the sampled bit
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_shift_en) begin
          r_q <= i_serial_in;
        end
      end
    end else begin : g_wide
      // Shift left so the earliest sampled bit migrates toward the MSB
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (i_shift_en) begin
          r_q <= {r_q[DATA_W-2:0], i_serial_in};
        end
      end
    end
  endgenerate

  assign o_q = r_q;

endmodule

// File: rtl/serial_frame_ctrl.sv
// rtl/serial_frame_ctrl.sv - start-bit detect, bit sampling, stop check and valid/ready word output
module serial_frame_ctrl
  import serial_frame_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_in,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = $clog2(BIT_CYCLES + 1);
  localparam int IDX_W = $clog2(DATA_W + 1);

  // Start bit is re-checked near the middle of its period
  localparam logic [CNT_W-1:0] HALF     = CNT_W'((BIT_CYCLES - 1) / 2);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [IDX_W-1:0]  r_idx;
  logic [IDX_W-1:0]  w_idx_nxt;
  logic              w_tick;
  logic              w_shift_en;
  logic              w_load;
  logic              w_ovr;
  logic              w_ferr;
  logic [DATA_W-1:0] w_sreg;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_frame_err;
  logic              r_overrun;

  // A sample point is reached whenever the cycle counter has run down to zero
  assign w_tick = (r_cnt == '0);

  sipo_shift_reg #(
    .DATA_W (DATA_W)
  ) u_sreg (
    .clk         (clk),
    .rst_n       (reset),
    .i_shift_en  (w_shift_en),
    .i_serial_in (serial_in),
    .o_q         (w_sreg)
  );

  // State, cycle counter and bit index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Frame sequencing: decide next state, counter reloads and the per-edge strobes
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shift_en  = 1'b0;
    w_load      = 1'b0;
    w_ovr       = 1'b0;
    w_ferr      = 1'b0;
    case (r_state)
      IDLE: begin
        if (serial_in == START_LEVEL) begin
          w_idx_nxt = '0;
          if (BIT_CYCLES == 1) begin
            // One cycle per bit: the edge that saw the start bit is its sample point
            w_state_nxt = DATA;
            w_cnt_nxt   = RELOAD;
          end else begin
            w_state_nxt = START;
            w_cnt_nxt   = HALF;
          end
        end
      end
      START: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else if (serial_in == START_LEVEL) begin
          w_state_nxt = DATA;
          w_cnt_nxt   = RELOAD;
          w_idx_nxt   = '0;
        end else begin
          // Glitch on an idle line: drop back silently
          w_state_nxt = IDLE;
        end
      end
      DATA: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_shift_en = 1'b1;
          w_cnt_nxt  = RELOAD;
          w_idx_nxt  = r_idx + IDX_ONE;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = STOP;
          end
        end
      end
      STOP: begin
        if (!w_tick) begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end else begin
          w_state_nxt = IDLE;
          if (serial_in != IDLE_LEVEL) begin
            w_ferr = 1'b1;
          end else if (!r_out_valid || out_ready) begin
            w_load = 1'b1;
          end else begin
            w_ovr = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Output word holding register with valid/ready handshake and one-cycle status pulses
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_ferr;
      r_overrun   <= w_ovr;
      if (w_load) begin
        // A freshly completed word wins over a same-edge consume
        r_out_data  <= w_sreg;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = (r_state != IDLE);
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// tb/tb_serial_frame_ctrl.sv - self-checking bench for serial_frame_ctrl
module tb_serial_frame_ctrl;

  localparam int DW = 4;
  localparam int MAXL = 600;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          sin_a, rdy_a, valid_a, busy_a, ferr_a, ovr_a;
  logic [DW-1:0] data_a;
  logic          sin_b, rdy_b, valid_b, busy_b, ferr_b, ovr_b;
  logic [DW-1:0] data_b;

  serial_frame_ctrl #(.DATA_W(DW), .BIT_CYCLES(1)) dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .serial_in (sin_a),
    .out_data  (data_a),
    .out_valid (valid_a),
    .out_ready (rdy_a),
    .busy      (busy_a),
    .frame_err (ferr_a),
    .overrun   (ovr_a)
  );

  serial_frame_ctrl #(.DATA_W(DW), .BIT_CYCLES(4)) dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .serial_in (sin_b),
    .out_data  (data_b),
    .out_valid (valid_b),
    .out_ready (rdy_b),
    .busy      (busy_b),
    .frame_err (ferr_b),
    .overrun   (ovr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge: drive the line, then advance past one rising edge to the next negedge
  task automatic step_a(input logic b, input logic r);
    sin_a = b;
    rdy_a = r;
    @(negedge clk);
  endtask

  task automatic step_b(input logic b, input logic r);
    sin_b = b;
    rdy_b = r;
    @(negedge clk);
  endtask

  task automatic send_a(input logic [DW-1:0] d, input logic stop, input logic r, input logic r_last);
    step_a(1'b0, r);
    for (int i = DW - 1; i >= 0; i--) step_a(d[i], r);
    step_a(stop, r_last);
  endtask

  typedef struct {
    logic [DW-1:0] data;
    logic          stop;
    logic          rdy;
    logic          rdy_last;
    int            gap;
    logic          gap_rdy;
    logic [DW-1:0] exp_d;
    logic          exp_v;
    logic          exp_fe;
    logic          exp_ov;
    logic          exp_v_gap;
  } vec_t;

  vec_t tbl [7];

  logic          line   [MAXL];
  logic          rdy_r  [MAXL];
  logic          busy_m [MAXL];
  int            ev     [MAXL];
  logic [DW-1:0] word   [MAXL];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exhausted, got running expected finished");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   len;
    int   t;
    int   w;
    logic mv, fe_m, ov_m;
    logic [DW-1:0] md;

    //          data     stp   rdy   rdyL  gap gapR  exp_d    v     fe    ov    v_gap
    tbl[0] = '{4'b1011, 1'b1, 1'b1, 1'b1, 1, 1'b1, 4'b1011, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'b1100, 1'b0, 1'b1, 1'b1, 1, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{4'b0110, 1'b1, 1'b1, 1'b1, 1, 1'b1, 4'b0110, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'b1010, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'b1010, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'b0101, 1'b1, 1'b0, 1'b0, 1, 1'b1, 4'b1010, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{4'b0001, 1'b1, 1'b0, 1'b0, 0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{4'b1110, 1'b1, 1'b0, 1'b1, 1, 1'b1, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0;
    sin_a = 1'b1; rdy_a = 1'b0;
    sin_b = 1'b1; rdy_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_data",  32'(data_a),  32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_busy",  32'(busy_a),  32'h0);
    chk("rst_ferr",  32'(ferr_a),  32'h0);
    chk("rst_ovr",   32'(ovr_a),   32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    rst_n = 1'b1;
    step_a(1'b1, 1'b1);

    // Table of single frames on the one-cycle-per-bit instance
    for (int i = 0; i < 7; i++) begin
      v = tbl[i];
      send_a(v.data, v.stop, v.rdy, v.rdy_last);
      chk($sformatf("t%0d_data", i),  32'(data_a),  32'(v.exp_d));
      chk($sformatf("t%0d_valid", i), 32'(valid_a), 32'(v.exp_v));
      chk($sformatf("t%0d_busy", i),  32'(busy_a),  32'h0);
      chk($sformatf("t%0d_ferr", i),  32'(ferr_a),  32'(v.exp_fe));
      chk($sformatf("t%0d_ovr", i),   32'(ovr_a),   32'(v.exp_ov));
      for (int g = 0; g < v.gap; g++) begin
        step_a(1'b1, v.gap_rdy);
        if (g == 0) begin
          chk($sformatf("t%0d_gap_valid", i), 32'(valid_a), 32'(v.exp_v_gap));
          chk($sformatf("t%0d_gap_ferr", i),  32'(ferr_a),  32'h0);
          chk($sformatf("t%0d_gap_ovr", i),   32'(ovr_a),   32'h0);
        end
      end
    end

    // False start at four cycles per bit
    step_b(1'b0, 1'b0);
    chk("fs_busy_start", 32'(busy_b), 32'h1);
    for (int i = 0; i < 5; i++) begin
      step_b(1'b1, 1'b0);
      chk($sformatf("fs_flags%0d", i), 32'({ferr_b, ovr_b, valid_b}), 32'h0);
    end
    chk("fs_busy_end", 32'(busy_b), 32'h0);

    // Full frame 1100 at four cycles per bit, consumer stalled until checked
    begin
      logic [DW+1:0] fb;
      fb = {1'b0, 4'b1100, 1'b1};
      for (int j = DW + 1; j >= 0; j--) begin
        for (int c = 0; c < 4; c++) step_b(fb[j], 1'b0);
      end
    end
    chk("b4_data",  32'(data_b),  32'hC);
    chk("b4_valid", 32'(valid_b), 32'h1);
    chk("b4_busy",  32'(busy_b),  32'h0);
    chk("b4_flags", 32'({ferr_b, ovr_b}), 32'h0);
    step_b(1'b1, 1'b1);
    chk("b4_consumed", 32'(valid_b), 32'h0);

    // Asynchronous reset in the middle of a frame
    send_a(4'b0011, 1'b1, 1'b0, 1'b0);
    chk("ar_pre_valid", 32'(valid_a), 32'h1);
    step_a(1'b0, 1'b0);
    step_a(1'b1, 1'b0);
    step_a(1'b0, 1'b0);
    chk("ar_pre_busy", 32'(busy_a), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_busy",  32'(busy_a),  32'h0);
    chk("ar_valid", 32'(valid_a), 32'h0);
    chk("ar_data",  32'(data_a),  32'h0);
    chk("ar_flags", 32'({ferr_a, ovr_a}), 32'h0);
    @(negedge clk);
    sin_a = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    send_a(4'b0111, 1'b1, 1'b1, 1'b1);
    chk("ar_after_data",  32'(data_a),  32'h7);
    chk("ar_after_valid", 32'(valid_a), 32'h1);
    step_a(1'b1, 1'b1);

    // Random frame stream against a frame-level reference model
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    len = 0;
    while (len < 450) begin
      int gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) line[len++] = 1'b1;
      line[len++] = 1'b0;
      for (int i = 0; i < DW; i++) line[len++] = 1'($urandom % 2);
      line[len++] = ($urandom_range(0, 4) == 0) ? 1'b0 : 1'b1;
    end
    for (int i = 0; i < DW + 2; i++) line[len++] = 1'b1;
    for (int k = 0; k < len; k++) begin
      rdy_r[k]  = 1'($urandom % 2);
      busy_m[k] = 1'b0;
      ev[k]     = 0;
      word[k]   = '0;
    end
    // A frame begins at any idle-sampled low; its stop sample lands DW+1 edges later
    t = 0;
    while (t < len) begin
      if (line[t] == 1'b0 && t + DW + 1 < len) begin
        for (int k = t; k <= t + DW; k++) busy_m[k] = 1'b1;
        w = 0;
        for (int i = 1; i <= DW; i++) w = w * 2 + int'(line[t + i]);
        word[t + DW + 1] = DW'(w);
        ev[t + DW + 1]   = line[t + DW + 1] ? 1 : 2;
        t = t + DW + 2;
      end else begin
        t++;
      end
    end
    mv = 1'b0;
    md = '0;
    for (int k = 0; k < len; k++) begin
      step_a(line[k], rdy_r[k]);
      fe_m = 1'b0;
      ov_m = 1'b0;
      if (ev[k] == 1) begin
        if (!mv || rdy_r[k]) begin
          mv = 1'b1;
          md = word[k];
        end else begin
          ov_m = 1'b1;
        end
      end else begin
        if (ev[k] == 2) fe_m = 1'b1;
        if (mv && rdy_r[k]) mv = 1'b0;
      end
      chk($sformatf("rnd%0d_data", k),  32'(data_a),  32'(md));
      chk($sformatf("rnd%0d_valid", k), 32'(valid_a), 32'(mv));
      chk($sformatf("rnd%0d_busy", k),  32'(busy_a),  32'(busy_m[k]));
      chk($sformatf("rnd%0d_ferr", k),  32'(ferr_a),  32'(fe_m));
      chk($sformatf("rnd%0d_ovr", k),   32'(ovr_a),   32'(ov_m));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/serial_frame_ctrl.md
Name: serial_frame_ctrl

Overview:
Receive controller that sequences a serial-in/parallel-out shift register. It detects a start bit on `serial_in` and generates the bit-sample strobes. It shifts DATA_W data bits, checks the stop bit, and then presents the assembled word on a valid/ready output port. It sits between the raw serial pin and downstream parallel consumers in the lab datapath.

Parameters:
DATA_W, 4, data bits per frame (≥1)
BIT_CYCLES, 1, clock cycles per serial bit period (≥1)

Ports:
clk  in  1  system clock, all state changes on rising edge
reset  in  1  asynchronous active-low reset (0 = in reset)
serial_in  in  1  serial line, idle high; frame = start(0), DATA_W data bits, stop(1)
out_data  out  DATA_W  received word; first received data bit in out_data[DATA_W-1]
out_valid  out  1  out_data holds an unconsumed word
out_ready  in  1  consumer accepts word when out_valid & out_ready at a rising edge
busy  out  1  high in any state other than IDLE
frame_err  out  1  one-cycle pulse: stop bit sampled as 0
overrun  out  1  one-cycle pulse: good frame completed while out_valid still high

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; out_data=0; out_valid=0; busy=0; frame_err=0; overrun=0; all counters 0. Reset mid-frame aborts the frame and produces no output.
- Sample offset: HALF = (BIT_CYCLES-1)/2, integer division. Sample interval = BIT_CYCLES.
- Counters:
  - Cycle counter, width $clog2(BIT_CYCLES+1).
  - Bit index, width $clog2(DATA_W+1).
  - Internal shift register, DATA_W bits, shift-left: sreg <= {sreg[DATA_W-2:0], serial_in}.
- IDLE:
  - serial_in=0 sampled at edge E0 → START, cycle counter loaded with HALF.
  - For BIT_CYCLES=1, the start check happens at E0 itself and the FSM goes directly to DATA.
- START:
  - Counter decrements each edge; at 0, serial_in is sampled.
  - Sample 0 → DATA, counter=BIT_CYCLES-1, bit index=0.
  - Sample 1 → false start → IDLE, with no flags.
- DATA:
  - At counter 0: shift serial_in into sreg, bit index++, reload counter=BIT_CYCLES-1.
  - After the DATA_W-th shift → STOP.
- STOP: at counter 0, sample serial_in.
  - 0 → frame_err=1 for one cycle, word discarded, go to IDLE.
  - 1 and out_valid=0, or out_valid=1 with out_ready=1 on the same edge → out_data<=sreg, out_valid<=1, go to IDLE.
  - 1 and out_valid=1 with out_ready=0 → overrun=1 for one cycle, new word dropped, held word unchanged, go to IDLE.
- Latency:
  - out_valid is high immediately after the stop-sample edge.
  - For BIT_CYCLES=1, that edge is the (DATA_W+2)-th edge counting E0 as the first.
- Output handshake:
  - out_valid=1 & out_ready=1 at an edge → out_valid<=0 unless a new word loads on the same edge; a new word takes priority and keeps out_valid=1.
  - out_data is stable while out_valid=1.
- Back-to-back frames: after STOP the FSM returns to IDLE. A start bit is accepted from the next edge, so consecutive frames need no idle gap.
- serial_in is assumed synchronous to clk (the bench drives it on negedge); no synchronizer inside.

Decomposition:
- Package serial_frame_pkg:
  - state enum {IDLE, START, DATA, STOP}
  - localparams IDLE_LEVEL=1'b1, START_LEVEL=1'b0
- One natural sub-module: sipo_shift_reg (DATA_W wide, with shift-enable and serial_in inputs, parallel q output), instanced under the FSM's shift strobe.
- FSM, counters and output register live in serial_frame_ctrl.

Test Plan:
- Basic frame, DATA_W=4, BIT_CYCLES=1, out_ready=1. Drive one bit per negedge: 0, 1,0,1,1, 1 → out_data=4'b1011, out_valid high 1 cycle, busy low afterwards, no flags.
- Bad stop bit: drive 0, 1,1,0,0, 0 → frame_err pulses 1 cycle; out_valid stays 0; next frame 0, 0,1,1,0, 1 → out_data=4'b0110.
- Backpressure/overrun, out_ready=0:
  - Send frames 1010 then 0101 back to back → out_data stays 4'b1010, out_valid stays 1, overrun pulses once.
  - Then raise out_ready → out_valid drops after 1 edge.
- False start with BIT_CYCLES=4:
  - Line low for 1 cycle then high → no state beyond START, busy returns low, no flags.
  - A full valid frame sent at 4 cycles/bit, data 1100 → out_data=4'b1100.
- Async reset mid-frame: assert reset=0 between rising edges after the 2nd data bit → busy, out_valid, flags go 0 immediately without waiting for a clock edge. After release, a fresh frame 0111 is received correctly.
- Simultaneous accept and load: out_valid=1 with word 0001, out_ready=1 on the exact edge a new frame 1110 completes → out_data=4'b1110, out_valid stays 1, no overrun.
